// File: rtl/alu_seq_pkg.sv
// alu_seq shared types: function codes, flag layout
// and multiplier FSM states.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    FN_LOAD = 4'd0,
    FN_COPY = 4'd1,
    FN_ADD  = 4'd2,
    FN_SUB  = 4'd3,
    FN_INV  = 4'd4,
    FN_FLIP = 4'd5,
    FN_AND  = 4'd6,
    FN_OR   = 4'd7,
    FN_XOR  = 4'd8,
    FN_LSL  = 4'd9,
    FN_LSR  = 4'd10,
    FN_ASR  = 4'd11,
    FN_ADDI = 4'd12,
    FN_SUBI = 4'd13,
    FN_MUL  = 4'd14,
    FN_CMP  = 4'd15
  } fn_e;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mul_state_e;

  function automatic logic [3:0] pack_flags(
    input logic z,
    input logic n,
    input logic c,
    input logic v
  );
    logic [3:0] f;
    f         = '0;
    f[FLAG_Z] = z;
    f[FLAG_N] = n;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Control-unit side of the ALU: operand, function,
// strobes and status returned to the sequencer.
interface alu_seq_if
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 10
);

  logic [WIDTH-1:0] OP;
  fn_e              FN;
  logic             Ain;
  logic             Gin;
  logic             Gout;
  logic [3:0]       Flags;
  logic             Busy;
  logic             Done;

  modport master (
    output OP, FN, Ain, Gin, Gout,
    input  Flags, Busy, Done
  );

  modport slave (
    input  OP, FN, Ain, Gin, Gout,
    output Flags, Busy, Done
  );

endinterface

// File: rtl/alu_seq_mul.sv
// Iterative shift-add multiplier, one partial
// product per clock; done flags the final step.
module alu_mul_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic             clkb,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0] mplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] prod_lo,
  output logic             hi_nz
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mul_state_e         state_q;
  mul_state_e         state_d;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_nx;

  assign acc_nx = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign prod_lo = acc_nx[WIDTH-1:0];
  assign hi_nz = |acc_nx[2*WIDTH-1:WIDTH];
  assign busy = (state_q == RUN);

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        if (cnt_q == LAST) begin
          state_d = IDLE;
          done    = 1'b1;
        end
      end
    endcase
  end

  always_ff @(negedge clkb) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(negedge clkb) begin
    if (rst) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (state_q == IDLE && start) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= {{WIDTH{1'b0}}, mcand};
      mplier_q <= mplier;
    end else if (state_q == RUN) begin
      cnt_q    <= cnt_q + CW'(1);
      acc_q    <= acc_nx;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Staged ALU: A operand reg, G result reg, Z/N/C/V
// status, iterative multiply and tri-state result bus.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int IMM_W = 6
) (
  input  logic             CLKb,
  input  logic             Rst,
  alu_seq_if.slave         bus,
  output wire  [WIDTH-1:0] RES
);

  localparam int SH_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MOST_NEG =
    {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] g_q;
  logic [3:0]       flags_q;
  logic             done_q;

  fn_e              fn;
  logic [WIDTH-1:0] op;
  logic [WIDTH-1:0] imm;
  logic [WIDTH-1:0] b;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   dif;
  logic [SH_W-1:0]  sh;
  logic             sat;
  logic             ovf_add;
  logic             ovf_sub;
  logic [WIDTH-1:0] r;
  logic             c;
  logic             v;

  logic             mul_start;
  logic             mul_busy;
  logic             mul_done;
  logic [WIDTH-1:0] mul_lo;
  logic             mul_hi;
  logic             exec_op;

  assign fn  = bus.FN;
  assign op  = bus.OP;
  assign imm = {{(WIDTH-IMM_W){1'b0}}, op[IMM_W-1:0]};
  assign b   = (fn == FN_ADDI || fn == FN_SUBI) ? imm : op;
  assign sum = {1'b0, a_q} + {1'b0, b};
  assign dif = {1'b0, a_q} - {1'b0, b};
  assign sh  = op[SH_W-1:0];
  // Shift amount is the whole operand, not just the low bits
  assign sat = (op >= WIDTH'(WIDTH));

  assign ovf_add = (a_q[WIDTH-1] == b[WIDTH-1]) &&
                   (sum[WIDTH-1] != a_q[WIDTH-1]);
  assign ovf_sub = (a_q[WIDTH-1] != b[WIDTH-1]) &&
                   (dif[WIDTH-1] != a_q[WIDTH-1]);

  always_comb begin
    r = '0;
    c = 1'b0;
    v = 1'b0;
    unique case (fn)
      FN_LOAD, FN_COPY: r = op;
      FN_ADD, FN_ADDI: begin
        r = sum[WIDTH-1:0];
        c = sum[WIDTH];
        v = ovf_add;
      end
      FN_SUB, FN_SUBI, FN_CMP: begin
        r = dif[WIDTH-1:0];
        c = dif[WIDTH];
        v = ovf_sub;
      end
      FN_INV: begin
        r = ~op + WIDTH'(1);
        v = (op == MOST_NEG);
      end
      FN_FLIP: r = ~op;
      FN_AND:  r = a_q & op;
      FN_OR:   r = a_q | op;
      FN_XOR:  r = a_q ^ op;
      FN_LSL:  r = sat ? '0 : (a_q << sh);
      FN_LSR:  r = sat ? '0 : (a_q >> sh);
      FN_ASR: begin
        if (sat) r = {WIDTH{a_q[WIDTH-1]}};
        else     r = $signed(a_q) >>> sh;
      end
      FN_MUL:  r = '0;
    endcase
  end

  // Gin is dropped entirely while a multiply owns G
  assign exec_op   = bus.Gin && !mul_busy && fn != FN_MUL;
  assign mul_start = bus.Gin && !mul_busy && fn == FN_MUL;

  alu_mul_seq #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clkb    (CLKb),
    .rst     (Rst),
    .start   (mul_start),
    .mcand   (a_q),
    .mplier  (op),
    .busy    (mul_busy),
    .done    (mul_done),
    .prod_lo (mul_lo),
    .hi_nz   (mul_hi)
  );

  always_ff @(negedge CLKb) begin
    if (Rst) begin
      a_q     <= '0;
      g_q     <= '0;
      flags_q <= '0;
      done_q  <= 1'b0;
    end else begin
      if (bus.Ain) a_q <= op;
      done_q <= mul_done;
      if (mul_done) begin
        g_q     <= mul_lo;
        flags_q <= pack_flags(mul_lo == '0,
                              mul_lo[WIDTH-1],
                              mul_hi, 1'b0);
      end else if (exec_op) begin
        if (fn != FN_CMP) g_q <= r;
        flags_q <= pack_flags(r == '0, r[WIDTH-1],
                              c, v);
      end
    end
  end

  assign bus.Flags = flags_q;
  assign bus.Busy  = mul_busy;
  assign bus.Done  = done_q;

  assign RES = bus.Gout ? g_q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: single-cycle ops, flags,
// shift saturation, multiply handshake and abort.
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int W = 10;

  logic CLKb = 1'b0;
  logic Rst  = 1'b0;
  always #5 CLKb = ~CLKb;

  alu_seq_if #(.WIDTH(W)) bus ();

  wire  [W-1:0] res_bus;
  logic         tb_en  = 1'b0;
  logic [W-1:0] tb_val = '0;
  assign res_bus = tb_en ? tb_val : {W{1'bz}};

  alu_seq #(
    .WIDTH (W),
    .IMM_W (6)
  ) dut (
    .CLKb (CLKb),
    .Rst  (Rst),
    .bus  (bus),
    .RES  (res_bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(negedge CLKb);
    #1;
  endtask

  task automatic load_a(input logic [W-1:0] val);
    bus.OP  = val;
    bus.Ain = 1'b1;
    tick();
    bus.Ain = 1'b0;
  endtask

  task automatic exec(input fn_e f,
                      input logic [W-1:0] val);
    bus.FN  = f;
    bus.OP  = val;
    bus.Gin = 1'b1;
    tick();
    bus.Gin = 1'b0;
  endtask

  task automatic test_reset();
    bus.Gout = 1'b1;
    Rst = 1'b1;
    tick();
    tick();
    Rst = 1'b0;
    checks++;
    if (res_bus !== 10'h000) begin
      errors++;
      $display("FAIL rst_res got %h want 000", res_bus);
    end
    checks++;
    if (bus.Flags !== 4'b0000) begin
      errors++;
      $display("FAIL rst_flags got %b want 0000",
               bus.Flags);
    end
    checks++;
    if (bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin
      errors++;
      $display("FAIL rst_busy got %b%b want 00",
               bus.Busy, bus.Done);
    end
    bus.Gout = 1'b0;
    tb_val = 10'h155;
    tb_en = 1'b1;
    #1;
    checks++;
    if (res_bus !== 10'h155) begin
      errors++;
      $display("FAIL rst_hiz got %h want 155", res_bus);
    end
    tb_en = 1'b0;
    bus.Gout = 1'b1;
    #1;
  endtask

  task automatic test_add();
    load_a(10'h1FF);
    exec(FN_ADD, 10'h001);
    checks++;
    if (res_bus !== 10'h200 || bus.Flags !== 4'b0101) begin
      errors++;
      $display("FAIL add_ovf got %h/%b want 200/0101",
               res_bus, bus.Flags);
    end
    load_a(10'h3FF);
    exec(FN_ADD, 10'h001);
    checks++;
    if (res_bus !== 10'h000 || bus.Flags !== 4'b1010) begin
      errors++;
      $display("FAIL add_carry got %h/%b want 000/1010",
               res_bus, bus.Flags);
    end
    bus.FN  = FN_ADD;
    bus.OP  = 10'h002;
    bus.Ain = 1'b1;
    bus.Gin = 1'b1;
    tick();
    bus.Ain = 1'b0;
    bus.Gin = 1'b0;
    checks++;
    if (res_bus !== 10'h001 || bus.Flags !== 4'b0010) begin
      errors++;
      $display("FAIL ain_gin got %h/%b want 001/0010",
               res_bus, bus.Flags);
    end
    exec(FN_ADD, 10'h003);
    checks++;
    if (res_bus !== 10'h005 || bus.Flags !== 4'b0000) begin
      errors++;
      $display("FAIL ain_gin_a got %h/%b want 005/0000",
               res_bus, bus.Flags);
    end
  endtask

  task automatic test_inv_cmp();
    exec(FN_INV, 10'h005);
    checks++;
    if (res_bus !== 10'h3FB || bus.Flags !== 4'b0100) begin
      errors++;
      $display("FAIL inv got %h/%b want 3FB/0100",
               res_bus, bus.Flags);
    end
    load_a(10'h003);
    exec(FN_CMP, 10'h005);
    checks++;
    if (res_bus !== 10'h3FB || bus.Flags !== 4'b0110) begin
      errors++;
      $display("FAIL cmp got %h/%b want 3FB/0110",
               res_bus, bus.Flags);
    end
    exec(FN_INV, 10'h200);
    checks++;
    if (res_bus !== 10'h200 || bus.Flags !== 4'b0101) begin
      errors++;
      $display("FAIL inv_neg got %h/%b want 200/0101",
               res_bus, bus.Flags);
    end
    load_a(10'h200);
    exec(FN_SUB, 10'h001);
    checks++;
    if (res_bus !== 10'h1FF || bus.Flags !== 4'b0001) begin
      errors++;
      $display("FAIL sub_ovf got %h/%b want 1FF/0001",
               res_bus, bus.Flags);
    end
    exec(FN_SUB, 10'h201);
    checks++;
    if (res_bus !== 10'h3FF || bus.Flags !== 4'b0110) begin
      errors++;
      $display("FAIL sub_brw got %h/%b want 3FF/0110",
               res_bus, bus.Flags);
    end
  endtask

  task automatic test_logic();
    load_a(10'h0F0);
    exec(FN_AND, 10'h3CC);
    checks++;
    if (res_bus !== 10'h0C0 || bus.Flags !== 4'b0000) begin
      errors++;
      $display("FAIL and got %h/%b want 0C0/0000",
               res_bus, bus.Flags);
    end
    exec(FN_OR, 10'h3CC);
    checks++;
    if (res_bus !== 10'h3FC || bus.Flags !== 4'b0100) begin
      errors++;
      $display("FAIL or got %h/%b want 3FC/0100",
               res_bus, bus.Flags);
    end
    exec(FN_XOR, 10'h3CC);
    checks++;
    if (res_bus !== 10'h33C) begin
      errors++;
      $display("FAIL xor got %h want 33C", res_bus);
    end
    exec(FN_FLIP, 10'h0F0);
    checks++;
    if (res_bus !== 10'h30F) begin
      errors++;
      $display("FAIL flip got %h want 30F", res_bus);
    end
    exec(FN_LOAD, 10'h123);
    checks++;
    if (res_bus !== 10'h123 || bus.Flags !== 4'b0000) begin
      errors++;
      $display("FAIL load got %h/%b want 123/0000",
               res_bus, bus.Flags);
    end
    exec(FN_COPY, 10'h000);
    checks++;
    if (res_bus !== 10'h000 || bus.Flags !== 4'b1000) begin
      errors++;
      $display("FAIL copy got %h/%b want 000/1000",
               res_bus, bus.Flags);
    end
  endtask

  task automatic test_shift();
    load_a(10'h201);
    exec(FN_LSR, 10'd1);
    checks++;
    if (res_bus !== 10'h100 || bus.Flags !== 4'b0000) begin
      errors++;
      $display("FAIL lsr1 got %h/%b want 100/0000",
               res_bus, bus.Flags);
    end
    exec(FN_ASR, 10'd1);
    checks++;
    if (res_bus !== 10'h300) begin
      errors++;
      $display("FAIL asr1 got %h want 300", res_bus);
    end
    exec(FN_LSL, 10'd1);
    checks++;
    if (res_bus !== 10'h002 || bus.Flags !== 4'b0000) begin
      errors++;
      $display("FAIL lsl1 got %h/%b want 002/0000",
               res_bus, bus.Flags);
    end
    exec(FN_LSL, 10'd12);
    checks++;
    if (res_bus !== 10'h000 || bus.Flags !== 4'b1000) begin
      errors++;
      $display("FAIL lsl12 got %h/%b want 000/1000",
               res_bus, bus.Flags);
    end
    exec(FN_ASR, 10'd12);
    checks++;
    if (res_bus !== 10'h3FF || bus.Flags !== 4'b0100) begin
      errors++;
      $display("FAIL asr12 got %h/%b want 3FF/0100",
               res_bus, bus.Flags);
    end
    exec(FN_LSR, 10'd10);
    checks++;
    if (res_bus !== 10'h000) begin
      errors++;
      $display("FAIL lsr10 got %h want 000", res_bus);
    end
    exec(FN_LSR, 10'd9);
    checks++;
    if (res_bus !== 10'h001) begin
      errors++;
      $display("FAIL lsr9 got %h want 001", res_bus);
    end
    exec(FN_ASR, 10'd9);
    checks++;
    if (res_bus !== 10'h3FF) begin
      errors++;
      $display("FAIL asr9 got %h want 3FF", res_bus);
    end
    load_a(10'h1FF);
    exec(FN_ASR, 10'h3FF);
    checks++;
    if (res_bus !== 10'h000 || bus.Flags !== 4'b1000) begin
      errors++;
      $display("FAIL asr_big got %h/%b want 000/1000",
               res_bus, bus.Flags);
    end
  endtask

  task automatic test_imm();
    load_a(10'h3FF);
    exec(FN_ADDI, 10'h3C1);
    checks++;
    if (res_bus !== 10'h000 || bus.Flags !== 4'b1010) begin
      errors++;
      $display("FAIL addi got %h/%b want 000/1010",
               res_bus, bus.Flags);
    end
    load_a(10'h005);
    exec(FN_SUBI, 10'h046);
    checks++;
    if (res_bus !== 10'h3FF || bus.Flags !== 4'b0110) begin
      errors++;
      $display("FAIL subi got %h/%b want 3FF/0110",
               res_bus, bus.Flags);
    end
  endtask

  task automatic test_mul();
    int bad;
    exec(FN_LOAD, 10'h0AB);
    load_a(10'd25);
    exec(FN_MUL, 10'd30);
    checks++;
    if (bus.Busy !== 1'b1 || res_bus !== 10'h0AB) begin
      errors++;
      $display("FAIL mul_start got %b/%h want 1/0AB",
               bus.Busy, res_bus);
    end
    bad = 0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      if (bus.Busy !== 1'b1 || bus.Done !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL mul_busy got %0d bad want 0", bad);
    end
    tick();
    checks++;
    if (bus.Busy !== 1'b0 || bus.Done !== 1'b1) begin
      errors++;
      $display("FAIL mul_done got %b%b want 01",
               bus.Busy, bus.Done);
    end
    checks++;
    if (res_bus !== 10'h2EE || bus.Flags !== 4'b0100) begin
      errors++;
      $display("FAIL mul_res got %h/%b want 2EE/0100",
               res_bus, bus.Flags);
    end
    tick();
    checks++;
    if (bus.Done !== 1'b0) begin
      errors++;
      $display("FAIL mul_pulse got %b want 0", bus.Done);
    end
    load_a(10'd100);
    exec(FN_MUL, 10'd20);
    tick();
    exec(FN_ADD, 10'd7);
    load_a(10'd1);
    for (int i = 4; i <= 9; i++) tick();
    checks++;
    if (bus.Busy !== 1'b1 || res_bus !== 10'h2EE) begin
      errors++;
      $display("FAIL mul_gin got %b/%h want 1/2EE",
               bus.Busy, res_bus);
    end
    tick();
    checks++;
    if (res_bus !== 10'h3D0 || bus.Flags !== 4'b0110 ||
        bus.Done !== 1'b1) begin
      errors++;
      $display("FAIL mul_hi got %h/%b/%b want 3D0/0110/1",
               res_bus, bus.Flags, bus.Done);
    end
    exec(FN_ADD, 10'd1);
    checks++;
    if (res_bus !== 10'h002 || bus.Flags !== 4'b0000) begin
      errors++;
      $display("FAIL mul_ain got %h/%b want 002/0000",
               res_bus, bus.Flags);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    load_a(10'd3);
    exec(FN_MUL, 10'd7);
    n = 0;
    while (bus.Done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n != 10 || res_bus !== 10'h015) begin
      errors++;
      $display("FAIL b2b_first got %0d/%h want 10/015",
               n, res_bus);
    end
    exec(FN_MUL, 10'd5);
    checks++;
    if (bus.Busy !== 1'b1 || bus.Done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_start got %b%b want 10",
               bus.Busy, bus.Done);
    end
    n = 0;
    while (bus.Done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n != 10 || res_bus !== 10'h00F ||
        bus.Flags !== 4'b0000) begin
      errors++;
      $display("FAIL b2b_second got %0d/%h/%b want 10/00F/0000",
               n, res_bus, bus.Flags);
    end
    tick();
  endtask

  task automatic test_abort();
    int pulses;
    load_a(10'd25);
    exec(FN_LOAD, 10'h055);
    exec(FN_MUL, 10'd30);
    tick();
    tick();
    tick();
    Rst = 1'b1;
    bus.OP = 10'h3FF;
    bus.Ain = 1'b1;
    tick();
    Rst = 1'b0;
    bus.Ain = 1'b0;
    checks++;
    if (bus.Busy !== 1'b0 || bus.Done !== 1'b0 ||
        res_bus !== 10'h000 || bus.Flags !== 4'b0000) begin
      errors++;
      $display("FAIL abort got %b%b/%h/%b want 00/000/0000",
               bus.Busy, bus.Done, res_bus, bus.Flags);
    end
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.Done !== 1'b0) pulses++;
    end
    checks++;
    if (pulses != 0 || res_bus !== 10'h000) begin
      errors++;
      $display("FAIL abort_quiet got %0d/%h want 0/000",
               pulses, res_bus);
    end
    exec(FN_ADD, 10'd5);
    checks++;
    if (res_bus !== 10'h005 || bus.Flags !== 4'b0000) begin
      errors++;
      $display("FAIL abort_add got %h/%b want 005/0000",
               res_bus, bus.Flags);
    end
  endtask

  initial begin
    bus.OP   = '0;
    bus.FN   = FN_LOAD;
    bus.Ain  = 1'b0;
    bus.Gin  = 1'b0;
    bus.Gout = 1'b0;
    test_reset();
    test_add();
    test_inv_cmp();
    test_logic();
    test_shift();
    test_imm();
    test_mul();
    test_back_to_back();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised successor to the datapath ALU: a WIDTH-bit staged ALU with an A operand register, G result register and tri-state result bus. Adds an ISA-correct two's-complement `inv`, saturating shift amounts, and a zero-extended immediate path. Adds a Z/N/C/V status register, a flags-only compare, and a multi-cycle iterative multiply with Busy/Done handshake. It sits on the shared processor bus under control of the control-unit FSM.

## Interface
- WIDTH, 10, datapath width in bits (≥4)
- IMM_W, 6, immediate field width; immediate = zero-extended OP[IMM_W-1:0]

Ports:
- CLKb  in  1  clock; all state updates on negedge
- Rst  in  1  synchronous active-high reset, sampled on negedge CLKb
- OP  in  WIDTH  common operand from bus
- FN  in  4  function select
- Ain  in  1  load A ← OP
- Gin  in  1  execute FN; write G and flags (or start MUL)
- Gout  in  1  drive RES from G
- RES  out  WIDTH  G when Gout=1, else high-Z
- Flags  out  4  {Z,N,C,V} status register
- Busy  out  1  multiply in progress
- Done  out  1  one-cycle pulse when MUL result is written to G

One clock; reset is synchronous and active-high.

## Operation
- FN codes:
  - LOAD 0: R = OP
  - COPY 1: R = OP
  - ADD 2: R = A+OP
  - SUB 3: R = A−OP
  - INV 4: R = −OP (~OP+1)
  - FLIP 5: R = ~OP
  - AND 6, OR 7, XOR 8
  - LSL 9, LSR 10, ASR 11: shift A by OP
  - ADDI 12: R = A+imm
  - SUBI 13: R = A−imm
  - MUL 14: R = low WIDTH bits of A×OP, unsigned, multi-cycle
  - CMP 15: flags from A−OP; G unchanged
- Shift amount is the full OP, unsigned. If OP ≥ WIDTH: LSL/LSR give 0; ASR gives all bits = A[WIDTH-1].
- Flags:
  - Z = (R==0); N = R[WIDTH-1].
  - ADD/ADDI: C = carry out. SUB/SUBI/CMP: C = borrow (A < operand, unsigned).
  - V = signed overflow for ADD/SUB/ADDI/SUBI/CMP. INV: C=0, V=1 iff OP = most-negative value.
  - MUL: C = 1 iff upper WIDTH bits of the product are nonzero; V=0.
  - All other ops: C=V=0.
- Multiply FSM: IDLE → RUN → IDLE.
  - IDLE with Gin=1 and FN=MUL: latch multiplicand=A and multiplier=OP into private registers, clear accumulator, counter=0, go to RUN.
  - RUN: one shift-add step per cycle. At step WIDTH, write G and flags, pulse Done, return to IDLE.
- Gin is ignored while Busy=1.
- Ain is honoured while Busy=1. A is independent of the in-flight multiply.
- Gout while Busy=1 drives the old G.
- Undefined behaviour does not exist: all 16 FN codes are defined.

## Timing
- Reset (Rst=1 at a negedge): A=0, G=0, Flags=0, Busy=0, Done=0, FSM=IDLE. RES is high-Z unless Gout=1, in which case it drives 0.
- Rst mid-multiply aborts with no G or flag write.
- Rst has priority over Ain and Gin.
- Single-cycle ops: Gin sampled at negedge k; G and Flags take R (using pre-edge A) at edge k. Latency 1 edge; Done stays 0.
- Ain and Gin together at edge k: G uses old A; A takes OP at the same edge.
- MUL started at edge k:
  - Busy=1 from edge k until edge k+WIDTH.
  - G, Flags and Done=1 are set at edge k+WIDTH.
  - Done clears at edge k+WIDTH+1.
  - A new MUL can start at edge k+WIDTH+1.
- RES is combinational from Gout and G.

## Structure
- Package `alu_seq_pkg`: `fn_e` enum (4-bit, codes above), flag bit indices (FLAG_Z=3, FLAG_N=2, FLAG_C=1, FLAG_V=0), `mul_state_e` {IDLE, RUN}.
- Sub-module `alu_mul_seq`: iterative shift-add multiplier with start, operands, busy, done, WIDTH-bit low product and high-nonzero flag.
- Top level holds the A/G/flag registers, combinational function unit and bus driver.

## Test plan
- Reset: Rst=1 for 2 edges with Gout=1 → RES=0, Flags=0000, Busy=0. With Gout=0 → RES = high-Z.
- ADD overflow: A=0x1FF, OP=0x001, FN=ADD, Gin → G=0x200, Flags Z=0 N=1 C=0 V=1. Then A=0x3FF, OP=1 → G=0, Z=1 C=1 V=0.
- INV/CMP:
  - OP=0x005, FN=INV → G=0x3FB.
  - A=3, OP=5, FN=CMP → Flags C=1 N=1, G still 0x3FB.
  - OP=0x200, INV → G=0x200, V=1.
- Shifts:
  - A=0x201, OP=1: LSR → 0x100; ASR → 0x300; LSL → 0x002.
  - OP=12: LSL → 0; ASR → 0x3FF.
- MUL: A=25, OP=30, FN=MUL, Gin at edge k → Busy high through edge k+9, G=750 (0x2EE) and Done pulse at edge k+10, C=0.
  - A=100, OP=20 → G=0x7D0 & 0x3FF = 0x3D0, C=1.
  - A second Gin during Busy has no effect.
- Abort: start MUL, assert Rst at edge k+4 → Busy=0, G=0, no Done pulse. A subsequent ADD behaves normally.
